matmul_sequencer: RTL
=====================

Name: matmul_sequencer

Overview:
Controller that sequences the 2x2 matrix-multiply core. It accepts eight operand bytes over a valid/ready stream (A00,A01,A10,A11,B00,B01,B10,B11) and writes each one into the core by driving its select/value/execute lines. It then reads back the four 17-bit products C00,C01,C10,C11 via the core's output select and emits them on a valid/ready result stream. It sits between the wishbone/LA-facing control logic and the core, so the core's load/execute protocol is never driven by software directly.

Parameters:
DW, 8, operand width; must match the core input width.
RW, 17, result width; must be 2*DW+1 to hold A[i][0]*B[0][j] + A[i][1]*B[1][j] without overflow.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
abort  input  1  synchronous cancel; returns to IDLE from any state.
in_valid  input  1  operand byte valid.
in_data  input  DW  operand byte, in the order A00,A01,A10,A11,B00,B01,B10,B11.
in_ready  output  1  operand accepted when in_valid && in_ready; combinational, equal to (state==LOAD).
out_valid  output  1  result valid (registered).
out_data  output  RW  result value (registered), in the order C00,C01,C10,C11.
out_ready  input  1  result consumer ready.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse after the 4th result handshake.
op_count  output  CNT_W  number of completed operations; wraps modulo 2^CNT_W.
mm_sel_in  output  3  core element select (registered).
mm_input_val  output  DW  core operand value (registered).
mm_execute  output  1  core execute (registered). 0 = core writes the selected element on the next edge; 1 = core holds its registers and drives its result.
mm_sel_out  output  2  core result select; equals the read index rd.
mm_result  input  RW  core result. It is combinational from the core's registers and is gated by mm_execute.

Behaviour:
- Reset values (asynchronous): state=IDLE, mm_execute=1, mm_sel_in=0, mm_input_val=0, rd=0 (so mm_sel_out=0), load count ld=0, out_valid=0, out_data=0, done=0, op_count=0.
- mm_execute is 1 in every cycle except the cycle immediately after an accepted operand. This matters because the core writes whenever execute=0, so a stray 0 corrupts an element.
- FSM states: IDLE, LOAD, SETTLE, READ, OUT.
- IDLE: if start && !abort, set ld=0 and go to LOAD. Otherwise stay.
- LOAD: in_ready=1. On an accept: mm_sel_in<=ld, mm_input_val<=in_data, mm_execute<=0, ld<=ld+1. With no accept: mm_execute<=1. Back-to-back accepts keep mm_execute=0 with a new select each cycle. Gaps in in_valid are allowed and must cause no writes. On the 8th accept (ld==7), go to SETTLE.
- SETTLE: one cycle so the core completes the B11 write. mm_execute<=1, rd<=0, go to READ.
- READ: out_data<=mm_result, out_valid<=1, go to OUT.
- OUT: hold out_valid and out_data until out_ready. On the handshake, out_valid<=0. If rd==3: go to IDLE, done<=1, op_count<=op_count+1. Otherwise rd<=rd+1 and go to READ.
- done is high for exactly one cycle, and only on normal completion.
- Timing, with in_valid and out_ready held high and start sampled at edge E0:
  - operands are accepted at E1..E8;
  - out_valid first rises after E10 (C00);
  - results are presented every 2 cycles;
  - done is asserted after E17.
- abort takes priority over every other event, including start in the same cycle and a same-cycle accept or handshake. From any state it goes to IDLE: mm_execute<=1, out_valid<=0, rd<=0, ld<=0, no done, op_count unchanged. Core registers keep any partial load; a later operation overwrites all 8 elements.
- start is ignored outside IDLE.
- Reset mid-operation returns everything to reset values immediately. This block does not drive the core's own reset.

Test Plan:
- Basic: load A=[[1,2],[3,4]], B=[[5,6],[7,8]] with in_valid and out_ready held high -> out_data 19, 22, 43, 50 in order; done pulse after E17; op_count=1.
- Max values: all 8 operands = 255 -> all four results = 130050 (0x1FC02); no truncation.
- Stalls: random in_valid gaps and out_ready held low for 5 cycles on C01 -> no extra core writes (mm_execute=0 exactly 8 cycles total); C01 held stable until the handshake; same results as Basic.
- Abort at ld=4, then start, then load Basic operands -> abort yields busy=0 with no done and op_count unchanged; the rerun gives 19, 22, 43, 50.
- Priority: start while busy is ignored; start+abort together in IDLE stays in IDLE; abort during OUT drops out_valid the next cycle.
- Asynchronous reset asserted mid-READ (between clock edges) -> outputs take reset values without waiting for a clock edge; mm_execute=1; op_count=0; op_count wraps 255->0 after 256 operations (reduce CNT_W to 2 to test quickly).

Source files
------------

// File: rtl/matmul_sequencer_if.sv
// Operand and result valid/ready streams between the control logic and
// the matrix-multiply sequencer. The sequencer connects through the slave modport.
interface matmul_sequencer_if #(
  parameter int DW = 8,
  parameter int RW = 17
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [RW-1:0] out_data;
  logic          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Sequencer for the 2x2 matrix-multiply core. It streams eight operand bytes
// into the core's element registers, lets the last write settle, then reads
// the four products back through the core's result select and emits them.
module matmul_sequencer #(
  parameter int DW    = 8,
  parameter int RW    = 17,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  matmul_sequencer_if.slave strm,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] op_count,
  output logic [2:0]       mm_sel_in,
  output logic [DW-1:0]    mm_input_val,
  output logic             mm_execute,
  output logic [1:0]       mm_sel_out,
  input  logic [RW-1:0]    mm_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_READ,
    S_OUT
  } state_t;

  state_t           state, state_n;
  logic [2:0]       ld, ld_n;
  logic [1:0]       rd, rd_n;
  logic             out_valid_n;
  logic [RW-1:0]    out_data_n;
  logic             done_n;
  logic [CNT_W-1:0] op_count_n;
  logic [2:0]       sel_in_n;
  logic [DW-1:0]    input_val_n;
  logic             execute_n;
  logic             accept;

  assign strm.in_ready = (state == S_LOAD);
  assign accept        = strm.in_valid && strm.in_ready;
  assign busy          = (state != S_IDLE);
  assign mm_sel_out    = rd;

  // Next-state and next-register values; abort overrides every other event.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_n     = state;
    ld_n        = ld;
    rd_n        = rd;
    out_valid_n = strm.out_valid;
    out_data_n  = strm.out_data;
    done_n      = 1'b0;
    op_count_n  = op_count;
    sel_in_n    = mm_sel_in;
    input_val_n = mm_input_val;
    execute_n   = 1'b1;  // the core writes whenever execute is low, so hold it high unless loading

    if (abort) begin
      state_n     = S_IDLE;
      ld_n        = 3'd0;
      rd_n        = 2'd0;
      out_valid_n = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ld_n    = 3'd0;
            state_n = S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            sel_in_n    = ld;
            input_val_n = strm.in_data;
            execute_n   = 1'b0;
            ld_n        = ld + 3'd1;
            if (ld == 3'd7) state_n = S_SETTLE;
          end
        end
        S_SETTLE: begin
          // The core commits B11 on this edge; results are valid afterwards.
          rd_n    = 2'd0;
          state_n = S_READ;
        end
        S_READ: begin
          out_data_n  = mm_result;
          out_valid_n = 1'b1;
          state_n     = S_OUT;
        end
        S_OUT: begin
          if (strm.out_ready) begin
            out_valid_n = 1'b0;
            if (rd == 2'd3) begin
              state_n    = S_IDLE;
              done_n     = 1'b1;
              op_count_n = op_count + 1'b1;
            end else begin
              rd_n    = rd + 2'd1;
              state_n = S_READ;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset to the idle values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ld            <= 3'd0;
      rd            <= 2'd0;
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
      done          <= 1'b0;
      op_count      <= '0;
      mm_sel_in     <= 3'd0;
      mm_input_val  <= '0;
      mm_execute    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state         <= state_n;
      ld            <= ld_n;
      rd            <= rd_n;
      strm.out_valid <= out_valid_n;
      strm.out_data  <= out_data_n;
      done          <= done_n;
      op_count      <= op_count_n;
      mm_sel_in     <= sel_in_n;
      mm_input_val  <= input_val_n;
      mm_execute    <= execute_n;
    end
  end

endmodule
